// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - in-order writeback queue driving the register file write port.
// Optional operand forwarding of pending writes is compiled in with RF_WB_FWD_EN.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 3,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [AW-1:0]    wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             rf_stall,
  output logic [WIDTH-1:0] rf_in,
  output logic [AW-1:0]    rf_w,
  output logic             rf_we,
  input  logic [AW-1:0]    fwd_r1,
  input  logic [AW-1:0]    fwd_r2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [WIDTH-1:0] fwd_data1,
  output logic [WIDTH-1:0] fwd_data2,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    reg_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;

  // Full blocks new writes even if the head drains this cycle: no pass-through.
  assign wb_ready = (count != CW'(DEPTH)) && !rst;
  assign push     = wb_valid && wb_ready;
  assign rf_we    = (count != '0) && !rf_stall;
  assign rf_in    = data_mem[head];
  assign rf_w     = reg_mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        reg_mem[tail]  <= wb_reg;
        data_mem[tail] <= wb_data;
        tail           <= tail + PW'(1);
      end
      if (rf_we) begin
        head <= head + PW'(1);
      end
      case ({push, rf_we})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RF_WB_FWD_EN
  // Scan oldest to youngest so the last match (closest to tail) wins.
  function automatic logic [WIDTH:0] lookup(input logic [AW-1:0] r);
    logic [WIDTH:0] res;
    logic [PW-1:0]  idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (reg_mem[idx] == r)) begin
        res = {1'b1, data_mem[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = lookup(fwd_r1);
    {fwd_hit2, fwd_data2} = lookup(fwd_r2);
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{fwd_r1, fwd_r2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb/tb_rf_wb_queue.sv - scoreboard bench for rf_wb_queue (DEPTH=4).
// Build with or without RF_WB_FWD_EN; forwarding expectations follow the macro.
module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int AW    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic             rf_stall;
  logic [WIDTH-1:0] rf_in;
  logic [AW-1:0]    rf_w;
  logic             rf_we;
  logic [AW-1:0]    fwd_r1;
  logic [AW-1:0]    fwd_r2;
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic [WIDTH-1:0] fwd_data1;
  logic [WIDTH-1:0] fwd_data2;
  logic [CW-1:0]    count;

  rf_wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_stall(rf_stall), .rf_in(rf_in), .rf_w(rf_w), .rf_we(rf_we),
    .fwd_r1(fwd_r1), .fwd_r2(fwd_r2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [AW+WIDTH-1:0] sb [$];

`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [AW-1:0] r, input logic [WIDTH-1:0] d);
    int waited = 0;
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    @(negedge clk);
    while (!wb_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!wb_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got wb_ready=0 expected 1 within 20 cycles");
    end else begin
      sb.push_back({r, d});
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  // Monitor: every cycle with rf_we high must commit the oldest expected write.
  initial begin
    logic [AW+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rf_we) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got rf_w=%0d rf_in=0x%0h expected no write", rf_w, rf_in);
        end else begin
          e = sb.pop_front();
          check("drain_reg", 32'(rf_w), 32'(e[AW+WIDTH-1:WIDTH]));
          check("drain_data", rf_in, e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    rf_stall = 1'b0; fwd_r1 = 3'd0; fwd_r2 = 3'd0;
    tick();
    tick();
    check("rst_wb_ready", 32'(wb_ready), 0);
    check("rst_count", 32'(count), 0);
    check("rst_rf_we", 32'(rf_we), 0);
    check("rst_rf_in", rf_in, 0);
    check("rst_rf_w", 32'(rf_w), 0);
    check("rst_fwd_hit1", 32'(fwd_hit1), 0);
    check("rst_fwd_data2", fwd_data2, 0);
    rst = 1'b0;
    #1;
    check("post_rst_wb_ready", 32'(wb_ready), 1);

    // Single write: visible on the write port the cycle after acceptance.
    send(3'd5, 32'hDEADBEEF);
    check("single_rf_we", 32'(rf_we), 1);
    check("single_rf_w", 32'(rf_w), 5);
    check("single_rf_in", rf_in, 32'hDEADBEEF);
    check("single_count", 32'(count), 1);
    tick();
    check("single_count_after", 32'(count), 0);
    check("single_rf_we_after", 32'(rf_we), 0);

    // Fill while stalled, includes a WAW pair on r3.
    rf_stall = 1'b1;
    send(3'd3, 32'h11);
    send(3'd3, 32'h22);
    send(3'd6, 32'h66);
    send(3'd7, 32'h77);
    check("full_count", 32'(count), 4);
    check("full_wb_ready", 32'(wb_ready), 0);
    check("full_rf_we", 32'(rf_we), 0);
    fwd_r1 = 3'd3; fwd_r2 = 3'd4;
    #1;
    check("waw_hit1", 32'(fwd_hit1), 32'(FWD));
    check("waw_data1", fwd_data1, FWD ? 32'h22 : 32'h0);
    check("miss_hit2", 32'(fwd_hit2), 0);
    check("miss_data2", fwd_data2, 0);
    rf_stall = 1'b0;
    fwd_r2 = 3'd7;
    #1;
    check("drain_rf_we", 32'(rf_we), 1);
    check("full_drain_no_passthru", 32'(wb_ready), 0);
    check("youngest_hit2", 32'(fwd_hit2), 32'(FWD));
    tick();
    check("after_first_drain_count", 32'(count), 3);
    check("after_first_drain_ready", 32'(wb_ready), 1);
    tick();
    tick();
    check("last_entry_count", 32'(count), 1);
    check("head_writing_hit2", 32'(fwd_hit2), 32'(FWD));
    check("head_writing_data2", fwd_data2, FWD ? 32'h77 : 32'h0);
    check("r3_gone_hit1", 32'(fwd_hit1), 0);
    tick();
    check("drained_count", 32'(count), 0);
    check("drained_hit2", 32'(fwd_hit2), 0);

    // Steady state at count=2; tail wraps past entry 3 back to 0.
    rf_stall = 1'b1;
    send(3'd1, 32'hA1);
    send(3'd2, 32'hA2);
    check("steady_pre_count", 32'(count), 2);
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(AW'(i + 4), 32'hB0 + 32'(i));
      check("steady_count", 32'(count), 2);
    end
    tick();
    tick();
    check("steady_drained_count", 32'(count), 0);

    // Asynchronous reset mid-cycle with a write on the port.
    rf_stall = 1'b1;
    send(3'd1, 32'hC1);
    send(3'd2, 32'hC2);
    send(3'd3, 32'hC3);
    check("pre_reset_count", 32'(count), 3);
    rf_stall = 1'b0;
    #1;
    check("pre_reset_rf_we", 32'(rf_we), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rf_we", 32'(rf_we), 0);
    check("async_count", 32'(count), 0);
    check("async_wb_ready", 32'(wb_ready), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    #1;
    check("post_async_ready", 32'(wb_ready), 1);
    repeat (5) tick();
    check("post_async_count", 32'(count), 0);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
